// File: rtl/wb_regfile.sv
// wb_regfile: write-back stage and architectural register file of the
// 5-stage MIPS pipeline.
//   - Selects the write-back value: ReadData (load) or ALUResult.
//   - Commits it to a 32 x 32-bit register file on the rising clock edge.
//   - Serves two combinational decode-stage read ports. Each port bypasses
//     a same-cycle write, so a value is visible in the cycle it is written.
//   - Register 0 is hardwired to zero.
//   - Counts retired (committed) writes for debug and performance monitoring.
//
// Ports:
//   clk            in   clock; all state updates on the rising edge
//   rst            in   synchronous reset, active-high
//   MemToReg       in   1 selects ReadData, 0 selects ALUResult
//   RegWrite       in   write enable for this write-back
//   ReadData       in   [31:0] data-memory load value
//   ALUResult      in   [31:0] ALU result
//   DestinationReg in   [4:0]  destination register index
//   ReadReg1       in   [4:0]  decode-stage source index rs
//   ReadReg2       in   [4:0]  decode-stage source index rt
//   ReadData1      out  [31:0] value of ReadReg1 (combinational, bypassed)
//   ReadData2      out  [31:0] value of ReadReg2 (combinational, bypassed)
//   WriteBackData  out  [31:0] selected write-back value (combinational)
//   WriteCount     out  [31:0] committed writes since reset (wraps silently)
module wb_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemToReg,
  input  logic        RegWrite,
  input  logic [31:0] ReadData,
  input  logic [31:0] ALUResult,
  input  logic [4:0]  DestinationReg,
  input  logic [4:0]  ReadReg1,
  input  logic [4:0]  ReadReg2,
  output logic [31:0] ReadData1,
  output logic [31:0] ReadData2,
  output logic [31:0] WriteBackData,
  output logic [31:0] WriteCount
);

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;

  // Entry 0 is never written and never read through the ports, so it
  // reduces to a constant.
  logic [DATA_W-1:0] regs [DEPTH];
  logic [DATA_W-1:0] writeCountQ;
  logic              commitWrite;

  // Read-port priority: reset, then r0, then same-cycle bypass, then array.
  function automatic logic [DATA_W-1:0] readPort(
    input logic              inReset,
    input logic [ADDR_W-1:0] idx,
    input logic              wrEn,
    input logic [ADDR_W-1:0] wrIdx,
    input logic [DATA_W-1:0] wrData,
    input logic [DATA_W-1:0] arrData
  );
    logic [DATA_W-1:0] val;
    if (inReset)
      val = '0;
    else if (idx == '0)
      val = '0;
    else if (wrEn && (wrIdx == idx))
      val = wrData;
    else
      val = arrData;
    return val;
  endfunction

  assign WriteBackData = MemToReg ? ReadData : ALUResult;

  // Writes to r0 are dropped entirely: no array update, no count.
  assign commitWrite = RegWrite && (DestinationReg != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= '0;
      writeCountQ <= '0;
    end else if (commitWrite) begin
      regs[DestinationReg] <= WriteBackData;
      writeCountQ          <= writeCountQ + 1'b1;
    end
  end

  assign WriteCount = writeCountQ;

  always_comb begin
    ReadData1 = readPort(rst, ReadReg1, RegWrite, DestinationReg,
                         WriteBackData, regs[ReadReg1]);
    ReadData2 = readPort(rst, ReadReg2, RegWrite, DestinationReg,
                         WriteBackData, regs[ReadReg2]);
  end

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;

  logic        clk;
  logic        rst;
  logic        MemToReg;
  logic        RegWrite;
  logic [31:0] ReadData;
  logic [31:0] ALUResult;
  logic [4:0]  DestinationReg;
  logic [4:0]  ReadReg1;
  logic [4:0]  ReadReg2;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic [31:0] WriteBackData;
  logic [31:0] WriteCount;

  wb_regfile dut (
    .clk           (clk),
    .rst           (rst),
    .MemToReg      (MemToReg),
    .RegWrite      (RegWrite),
    .ReadData      (ReadData),
    .ALUResult     (ALUResult),
    .DestinationReg(DestinationReg),
    .ReadReg1      (ReadReg1),
    .ReadReg2      (ReadReg2),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2),
    .WriteBackData (WriteBackData),
    .WriteCount    (WriteCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: architectural register contents and retired-write count.
  logic [31:0] mdlRegs [32];
  logic [31:0] mdlCount;

  int tests;
  int failed;

  logic [31:0] lastRd1, lastRd2, lastWbd, lastCnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] expRead(input logic r, input logic [4:0] idx,
                                          input logic we, input logic [4:0] dst,
                                          input logic [31:0] wbd);
    if (r) return 32'h0;
    if (idx == 5'd0) return 32'h0;
    if (we && dst == idx) return wbd;
    return mdlRegs[idx];
  endfunction

  // One cycle: drive inputs, check outputs at the falling edge against the
  // model, then let the rising edge commit and update the model.
  task automatic step(input logic r, input logic mtr, input logic we,
                      input logic [31:0] rdat, input logic [31:0] alu,
                      input logic [4:0] dst, input logic [4:0] r1, input logic [4:0] r2);
    logic [31:0] wbd;
    rst = r; MemToReg = mtr; RegWrite = we; ReadData = rdat; ALUResult = alu;
    DestinationReg = dst; ReadReg1 = r1; ReadReg2 = r2;
    wbd = mtr ? rdat : alu;
    @(negedge clk);
    lastRd1 = ReadData1; lastRd2 = ReadData2; lastWbd = WriteBackData; lastCnt = WriteCount;
    chk("wbd", WriteBackData, wbd);
    chk("rd1", ReadData1, expRead(r, r1, we, dst, wbd));
    chk("rd2", ReadData2, expRead(r, r2, we, dst, wbd));
    chk("cnt", WriteCount, mdlCount);
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) mdlRegs[i] = 32'h0;
      mdlCount = 32'h0;
    end else if (we && dst != 5'd0) begin
      mdlRegs[dst] = wbd;
      mdlCount = mdlCount + 32'h1;
    end
    #1;
  endtask

  initial begin
    tests = 0; failed = 0;
    for (int i = 0; i < 32; i++) mdlRegs[i] = 32'h0;
    mdlCount = 32'h0;
    rst = 1'b1; MemToReg = 1'b0; RegWrite = 1'b0; ReadData = '0; ALUResult = '0;
    DestinationReg = '0; ReadReg1 = '0; ReadReg2 = '0;

    // Reset cycles (reads forced to zero while rst=1, even with a write pending)
    @(posedge clk); #1;
    step(1'b1, 1'b0, 1'b1, 32'h0, 32'hFFFF_FFFF, 5'd4, 5'd4, 5'd4);
    chk("rst_rd1", lastRd1, 32'h0);

    // All indices read zero after reset
    for (int i = 0; i < 32; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'(i), 5'(31 - i));
      chk("reset_rd1", lastRd1, 32'h0);
      chk("reset_rd2", lastRd2, 32'h0);
    end
    chk("reset_cnt", lastCnt, 32'h0);

    // Same-cycle bypass, then array read
    step(1'b0, 1'b0, 1'b1, 32'h0, 32'h1234_5678, 5'd5, 5'd5, 5'd0);
    chk("bypass_rd1", lastRd1, 32'h1234_5678);
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd5);
    chk("array_rd1", lastRd1, 32'h1234_5678);
    chk("cnt_one", lastCnt, 32'h1);

    // Write to r0 dropped
    step(1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h1, 5'd0, 5'd0, 5'd0);
    chk("r0_wbd", lastWbd, 32'hDEAD_BEEF);
    chk("r0_rd1", lastRd1, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd5);
    chk("r0_cnt", lastCnt, 32'h1);
    chk("r0_rd1_after", lastRd1, 32'h0);

    // No bypass when RegWrite=0
    step(1'b0, 1'b0, 1'b1, 32'h0, 32'hAAAA_0001, 5'd7, 5'd0, 5'd0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h5, 5'd7, 5'd0, 5'd7);
    chk("nobypass_rd2", lastRd2, 32'hAAAA_0001);
    chk("cnt_two", lastCnt, 32'h2);

    // Reset dominates a write in the same cycle
    step(1'b0, 1'b0, 1'b1, 32'h0, 32'h11, 5'd3, 5'd3, 5'd0);
    step(1'b1, 1'b0, 1'b1, 32'h0, 32'h22, 5'd3, 5'd3, 5'd3);
    chk("rstwr_rd1", lastRd1, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd7);
    chk("rstwr_r3", lastRd1, 32'h0);
    chk("rstwr_r7", lastRd2, 32'h0);
    chk("rstwr_cnt", lastCnt, 32'h0);

    // First write after reset commits normally
    step(1'b0, 1'b1, 1'b1, 32'hCAFE_F00D, 32'h0, 5'd9, 5'd0, 5'd0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd9, 5'd9);
    chk("post_rst_r9", lastRd1, 32'hCAFE_F00D);
    chk("post_rst_cnt", lastCnt, 32'h1);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic        r, mtr, we;
      logic [4:0]  dst, r1, r2;
      r   = ($urandom_range(0, 39) == 0);
      mtr = 1'($urandom);
      we  = ($urandom_range(0, 3) != 0);
      dst = 5'($urandom_range(0, 31));
      r1  = ($urandom_range(0, 2) == 0) ? dst : 5'($urandom_range(0, 31));
      r2  = ($urandom_range(0, 2) == 0) ? dst : 5'($urandom_range(0, 31));
      step(r, mtr, we, $urandom, $urandom, dst, r1, r2);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
